// File: rtl/sram_like_arbiter.sv
// Two-channel SRAM-like arbiter: data has fixed priority, a stalled grant is locked until it is accepted,
// and an in-order owner FIFO routes each data_ok/rdata back to the channel that issued the request.
module sram_like_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             lock_q, lock_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;

  logic grant_vld;
  logic grant_sel;   // 0 = IF, 1 = DATA
  logic push;
  logic pop;
  logic head;

  // A locked grant stays with its owner even if the other channel has priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (lock_q) begin
      grant_sel = lock_owner_q;
      grant_vld = lock_owner_q ? data_req : inst_req;
    end else if (data_req) begin
      grant_sel = 1'b1;
      grant_vld = 1'b1;
    end else if (inst_req) begin
      grant_sel = 1'b0;
      grant_vld = 1'b1;
    end
  end

  assign req = !reset && grant_vld && (count_q < DEPTH_C);

  always_comb begin
    wr    = 1'b0;
    size  = 2'd0;
    addr  = 32'd0;
    wstrb = 4'd0;
    wdata = 32'd0;
    if (req) begin
      if (grant_sel) begin
        wr    = data_wr;
        size  = data_size;
        addr  = data_addr;
        wstrb = data_wstrb;
        wdata = data_wdata;
      end else begin
        wr    = inst_wr;
        size  = inst_size;
        addr  = inst_addr;
        wstrb = inst_wstrb;
        wdata = inst_wdata;
      end
    end
  end

  assign push         = req && addr_ok;
  assign inst_addr_ok = push && !grant_sel;
  assign data_addr_ok = push && grant_sel;

  // A data_ok with nothing outstanding is dropped rather than popped.
  assign head         = fifo_q[rptr_q];
  assign pop          = !reset && data_ok && (count_q != '0);
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    fifo_d       = fifo_q;
    if (reset) begin
      lock_d       = 1'b0;
      lock_owner_d = 1'b0;
      count_d      = '0;
      wptr_d       = '0;
      rptr_d       = '0;
    end else begin
      if (req && !addr_ok) begin
        lock_d       = 1'b1;
        lock_owner_d = grant_sel;
      end else if (push) begin
        lock_d = 1'b0;
      end
      if (push) begin
        fifo_d[wptr_q] = grant_sel;
        wptr_d         = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    lock_q       <= lock_d;
    lock_owner_q <= lock_owner_d;
    count_q      <= count_d;
    wptr_q       <= wptr_d;
    rptr_q       <= rptr_d;
    fifo_q       <= fifo_d;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table for the corner cases, then random traffic
// compared against a queue-based reference model of the grant/lock/ordering rules.
module tb_sram_like_arbiter;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  sram_like_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iaok;
    logic        e_daok;
    logic        e_idok;
    logic        e_ddok;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model state: owner queue (0=IF, 1=DATA) and the pending-stall lock.
  bit   owners[$];
  bit   m_lock = 1'b0;
  bit   m_own  = 1'b0;

  function automatic void add(input logic rst, input logic ireq, input logic [31:0] iaddr,
                              input logic dreq, input logic [31:0] daddr, input logic aok,
                              input logic dok, input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_iaok, input logic e_daok,
                              input logic e_idok, input logic e_ddok);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.aok = aok; v.dok = dok; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [159:0] act,
                       input logic [159:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //   rst ireq iaddr         dreq daddr        aok dok rd            req addr          iaok daok idok ddok
    add(1, 1, 32'h1C00_0000, 1, 32'h200,      1, 1, 32'h0,          0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'h1C00_0000, 0, 32'h0,        1, 0, 32'h0,          1, 32'h1C00_0000, 1, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'hDEAD_BEEF,  0, 32'h0,         0, 0, 1, 0);
    add(0, 1, 32'h100,       1, 32'h200,      1, 0, 32'h0,          1, 32'h200,       0, 1, 0, 0);
    add(0, 1, 32'h100,       0, 32'h0,        1, 0, 32'h0,          1, 32'h100,       1, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h1,          0, 32'h0,         0, 0, 0, 1);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h2,          0, 32'h0,         0, 0, 1, 0);
    add(0, 1, 32'h100,       0, 32'h0,        0, 0, 32'h0,          1, 32'h100,       0, 0, 0, 0);
    add(0, 1, 32'h100,       1, 32'h200,      0, 0, 32'h0,          1, 32'h100,       0, 0, 0, 0);
    add(0, 1, 32'h100,       1, 32'h200,      0, 0, 32'h0,          1, 32'h100,       0, 0, 0, 0);
    add(0, 1, 32'h100,       1, 32'h200,      1, 0, 32'h0,          1, 32'h100,       1, 0, 0, 0);
    add(0, 0, 32'h0,         1, 32'h200,      1, 0, 32'h0,          1, 32'h200,       0, 1, 0, 0);
    add(0, 1, 32'h300,       0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'h300,       0, 32'h0,        1, 1, 32'h5,          0, 32'h0,         0, 0, 1, 0);
    add(0, 1, 32'h300,       0, 32'h0,        1, 0, 32'h0,          1, 32'h300,       1, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h6,          0, 32'h0,         0, 0, 0, 1);
    add(0, 0, 32'h0,         1, 32'h400,      1, 1, 32'h7,          1, 32'h400,       0, 1, 1, 0);
    add(0, 1, 32'h500,       0, 32'h0,        1, 0, 32'h0,          1, 32'h500,       1, 0, 0, 0);
    add(0, 1, 32'h500,       0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h8,          0, 32'h0,         0, 0, 0, 1);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h9,          0, 32'h0,         0, 0, 1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'hA,          0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'h600,       0, 32'h0,        1, 0, 32'h0,          1, 32'h600,       1, 0, 0, 0);
    add(0, 0, 32'h0,         1, 32'h700,      1, 0, 32'h0,          1, 32'h700,       0, 1, 0, 0);
    add(0, 1, 32'h600,       0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
    add(1, 1, 32'h600,       1, 32'h700,      1, 1, 32'hB,          0, 32'h0,         0, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'hC,          0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'h800,       0, 32'h0,        0, 0, 32'h0,          1, 32'h800,       0, 0, 0, 0);
    add(0, 1, 32'h800,       1, 32'h900,      1, 0, 32'h0,          1, 32'h800,       1, 0, 0, 0);
    add(0, 0, 32'h0,         1, 32'h900,      0, 0, 32'h0,          1, 32'h900,       0, 0, 0, 0);
    add(1, 0, 32'h0,         1, 32'h900,      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'hA00,       0, 32'h0,        1, 0, 32'h0,          1, 32'hA00,       1, 0, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'hD,          0, 32'h0,         0, 0, 1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'hE,          0, 32'h0,         0, 0, 0, 0);

    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'h5555_AAAA;

    foreach (tbl[i]) begin
      reset     = tbl[i].rst;
      inst_req  = tbl[i].ireq;
      inst_addr = tbl[i].iaddr;
      data_req  = tbl[i].dreq;
      data_addr = tbl[i].daddr;
      addr_ok   = tbl[i].aok;
      data_ok   = tbl[i].dok;
      rdata     = tbl[i].rd;
      @(negedge clk);
      check("table", i,
            160'({req, addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                  inst_rdata, data_rdata}),
            160'({tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iaok, tbl[i].e_daok,
                  tbl[i].e_idok, tbl[i].e_ddok, tbl[i].rd, tbl[i].rd}));
      @(posedge clk); #1;
    end

    // Force a known starting point for the model.
    reset = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      bit          e_req, g, has_g, full, e_pop, e_push;
      logic [31:0] e_addr, e_wdata;
      logic        e_wr;
      logic [1:0]  e_size;
      logic [3:0]  e_wstrb;

      reset      = ($urandom_range(99) == 0);
      inst_req   = 1'($urandom_range(1));
      inst_wr    = 1'($urandom_range(1));
      inst_size  = 2'($urandom_range(2));
      inst_addr  = $urandom;
      inst_wstrb = 4'($urandom);
      inst_wdata = $urandom;
      data_req   = ($urandom_range(2) == 0);
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom;
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
      addr_ok    = ($urandom_range(9) < 6);
      data_ok    = ($urandom_range(9) < 4);
      rdata      = $urandom;

      if (m_lock) begin
        g = m_own; has_g = m_own ? data_req : inst_req;
      end else begin
        g = data_req; has_g = data_req || inst_req;
      end
      full   = (owners.size() >= DEPTH);
      e_req  = !reset && has_g && !full;
      e_push = e_req && addr_ok;
      e_pop  = !reset && data_ok && (owners.size() != 0);
      e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wstrb = 4'd0; e_wdata = 32'd0;
      if (e_req) begin
        e_wr    = g ? data_wr    : inst_wr;
        e_size  = g ? data_size  : inst_size;
        e_addr  = g ? data_addr  : inst_addr;
        e_wstrb = g ? data_wstrb : inst_wstrb;
        e_wdata = g ? data_wdata : inst_wdata;
      end

      @(negedge clk);
      check("random", c,
            160'({req, wr, size, addr, wstrb, wdata, inst_addr_ok, data_addr_ok,
                  inst_data_ok, data_data_ok, inst_rdata, data_rdata}),
            160'({e_req, e_wr, e_size, e_addr, e_wstrb, e_wdata, e_push && !g, e_push && g,
                  e_pop && !owners[0], e_pop && owners[0], rdata, rdata}));

      if (reset) begin
        owners.delete();
        m_lock = 1'b0;
        m_own  = 1'b0;
      end else begin
        if (e_req && !addr_ok) begin
          m_lock = 1'b1;
          m_own  = g;
        end else if (e_push) begin
          m_lock = 1'b0;
        end
        if (e_pop) void'(owners.pop_front());
        if (e_push) owners.push_back(g);
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
